// File: rtl/mac_pkg.sv
// mac_pkg
// Shared definitions for the 1.6TMII MAC frame generator and its receive
// checker: line codes, header addresses, field sizes, the generator state
// enum, and the byte-lane layout helper that maps a frame byte index onto
// its content.
// No ports (package).

package mac_pkg;

    // Line codes carried on the 8-lane control/data interface
    localparam logic [7:0] IDLE_CODE     = 8'h07;
    localparam logic [7:0] START_CODE    = 8'hFB;
    localparam logic [7:0] TERM_CODE     = 8'hFD;
    localparam logic [7:0] PREAMBLE_CODE = 8'h55;
    localparam logic [7:0] SFD_CODE      = 8'hD5;

    localparam logic [63:0] IDLE_WORD = {8{IDLE_CODE}};

    // Header addresses, transmitted least significant byte first
    localparam logic [47:0] DST_ADDR_CODE = 48'hFFFFFFFFFFFF;
    localparam logic [47:0] SRC_ADDR_CODE = 48'h123456789ABC;

    // Field sizes in bytes
    localparam int PREAMBLE_BYTES = 6;
    localparam int SFD_BYTES      = 1;
    localparam int DA_BYTES       = 6;
    localparam int SA_BYTES       = 6;
    localparam int LENGTH_BYTES   = 2;
    localparam int FCS_BYTES      = 4;
    localparam int MIN_PAYLOAD    = 46;
    localparam int MAX_PAYLOAD    = 1500;

    // Byte positions within a frame (byte 0 is the start code)
    localparam int SFD_POS        = 1 + PREAMBLE_BYTES;
    localparam int DA_POS         = SFD_POS + SFD_BYTES;
    localparam int SA_POS         = DA_POS + DA_BYTES;
    localparam int LEN_POS        = SA_POS + SA_BYTES;
    localparam int PAYLOAD_POS    = LEN_POS + LENGTH_BYTES;
    // Everything except the payload: start, preamble, SFD, DA, SA, length, FCS, terminate
    localparam int FRAME_OVERHEAD = PAYLOAD_POS + FCS_BYTES + 1;

    // Reflected IEEE 802.3 CRC-32 polynomial
    localparam logic [31:0] CRC32_POLY = 32'hEDB88320;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FRAME,
        ST_IPG
    } state_e;

    // What a single byte lane carries. LANE_CRC bytes are covered by the FCS,
    // LANE_PLAIN bytes (preamble/SFD) are data but not covered, and LANE_FCS
    // bytes are filled in later from the running CRC.
    typedef enum logic [1:0] {
        LANE_CTRL,
        LANE_PLAIN,
        LANE_CRC,
        LANE_FCS
    } lane_kind_e;

    typedef struct packed {
        lane_kind_e  kind;
        logic [1:0]  fcs_idx;
        logic [7:0]  value;
    } lane_info_t;

    function automatic logic len_is_legal(input logic [10:0] len);
        return (len >= 11'(MIN_PAYLOAD)) && (len <= 11'(MAX_PAYLOAD));
    endfunction

    // Content of frame byte b for payload length len and payload seed.
    // Bytes past the terminate code are idle control lanes.
    function automatic lane_info_t frame_lane(input logic [11:0] b,
                                              input logic [10:0] len,
                                              input logic [7:0]  seed);
        lane_info_t info;
        logic [11:0] fcs_start;
        logic [2:0]  addr_off;

        info.kind    = LANE_CTRL;
        info.fcs_idx = 2'd0;
        info.value   = IDLE_CODE;
        addr_off     = 3'd0;
        fcs_start    = 12'(PAYLOAD_POS) + {1'b0, len};

        if (b == 12'd0) begin
            info.value = START_CODE;
        end else if (b < 12'(SFD_POS)) begin
            info.kind  = LANE_PLAIN;
            info.value = PREAMBLE_CODE;
        end else if (b == 12'(SFD_POS)) begin
            info.kind  = LANE_PLAIN;
            info.value = SFD_CODE;
        end else if (b < 12'(SA_POS)) begin
            addr_off   = 3'(b - 12'(DA_POS));
            info.kind  = LANE_CRC;
            info.value = 8'(DST_ADDR_CODE >> {addr_off, 3'b000});
        end else if (b < 12'(LEN_POS)) begin
            addr_off   = 3'(b - 12'(SA_POS));
            info.kind  = LANE_CRC;
            info.value = 8'(SRC_ADDR_CODE >> {addr_off, 3'b000});
        end else if (b == 12'(LEN_POS)) begin
            info.kind  = LANE_CRC;
            info.value = len[7:0];
        end else if (b == 12'(LEN_POS + 1)) begin
            info.kind  = LANE_CRC;
            info.value = {5'd0, len[10:8]};
        end else if (b < fcs_start) begin
            info.kind  = LANE_CRC;
            info.value = seed + 8'(b - 12'(PAYLOAD_POS));
        end else if (b < fcs_start + 12'(FCS_BYTES)) begin
            info.kind    = LANE_FCS;
            info.fcs_idx = 2'(b - fcs_start);
            info.value   = 8'h00;
        end else if (b == fcs_start + 12'(FCS_BYTES)) begin
            info.value = TERM_CODE;
        end
        return info;
    endfunction

endpackage

// File: rtl/crc32_d64.sv
// crc32_d64
// Combinational CRC-32 (IEEE 802.3, reflected) update over up to eight byte
// lanes of a 64-bit word. Lane 0 is processed first; lanes whose enable bit
// is clear are skipped. No init or final complement is applied here.
// Ports:
//   crc_in   current CRC register value
//   data     64-bit word, lane i = bits [8i+7:8i]
//   lane_en  per-lane enable, bit i covers lane i
//   crc_out  CRC after absorbing the enabled lanes

module crc32_d64
    import mac_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [63:0] data,
    input  logic [7:0]  lane_en,
    output logic [31:0] crc_out
);

    logic [31:0] crc;

    // Byte-serial reflected CRC unrolled across the lanes; the synthesis tool
    // flattens this into a single XOR network.
    always_comb begin
        crc = crc_in;
        for (int lane = 0; lane < 8; lane++) begin
            if (lane_en[lane]) begin
                crc = crc ^ {24'd0, data[8*lane +: 8]};
                for (int bit_i = 0; bit_i < 8; bit_i++) begin
                    crc = crc[0] ? ((crc >> 1) ^ CRC32_POLY) : (crc >> 1);
                end
            end
        end
        crc_out = crc;
    end

endmodule

// File: rtl/mac_frame_generator.sv
// mac_frame_generator
// Builds complete Ethernet frames (start, preamble, SFD, DA, SA, length,
// incrementing payload, FCS, terminate) and streams them as 64-bit words with
// per-lane control bits, followed by a fixed idle gap.
// Ports:
//   clk            rising-edge clock
//   i_rst          asynchronous active-high reset
//   i_start        frame request, only looked at in IDLE
//   i_payload_len  payload byte count, legal 46..1500
//   i_seed         first payload byte, later bytes increment mod 256
//   i_tx_ready     downstream accepts the current word
//   o_tx_data      lane i = bits [8i+7:8i], lane 0 first on the wire
//   o_tx_ctrl      bit i set when lane i carries a control code
//   o_busy         high while a frame or its idle gap is in progress
//   o_done         one-cycle pulse after the terminate word is accepted
//   o_len_error    one-cycle pulse after a start with an illegal length
//   o_frame_count  completed frames, wrapping 16-bit count

module mac_frame_generator
    import mac_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int CTRL_WIDTH = 8,
    parameter int IPG_WORDS  = 2
) (
    input  logic                  clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic [10:0]           i_payload_len,
    input  logic [7:0]            i_seed,
    input  logic                  i_tx_ready,
    output logic [DATA_WIDTH-1:0] o_tx_data,
    output logic [CTRL_WIDTH-1:0] o_tx_ctrl,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_len_error,
    output logic [15:0]           o_frame_count
);

    localparam logic [7:0] IPG_LAST = 8'((IPG_WORDS > 0) ? (IPG_WORDS - 1) : 0);

    state_e      state_q, state_d;
    logic [63:0] tx_data_q;
    logic [7:0]  tx_ctrl_q;
    logic [7:0]  word_q;
    logic [31:0] crc_q;
    logic [10:0] len_q;
    logic [7:0]  seed_q;
    logic [7:0]  ipg_q, ipg_d;
    logic        done_q, done_d;
    logic        len_err_q, len_err_d;
    logic [15:0] frame_count_q, count_d;
    logic        load_word, load_idle;

    logic [10:0] cur_len;
    logic [7:0]  cur_seed;
    logic [31:0] crc_base;
    logic [7:0]  next_idx;
    logic [11:0] base_byte;
    logic [11:0] term_pos;
    logic [7:0]  last_word;

    lane_info_t  lanes [8];
    logic [63:0] crc_data;
    logic [7:0]  crc_mask;
    logic [31:0] crc_next;
    logic [31:0] fcs;
    logic [63:0] word_d;
    logic [7:0]  ctrl_d;

    // In IDLE the first word is built straight from the request inputs so it
    // can be registered on the same edge that samples i_start.
    assign cur_len   = (state_q == ST_IDLE) ? i_payload_len : len_q;
    assign cur_seed  = (state_q == ST_IDLE) ? i_seed : seed_q;
    assign crc_base  = (state_q == ST_IDLE) ? 32'hFFFFFFFF : crc_q;
    assign next_idx  = (state_q == ST_IDLE) ? 8'd0 : word_q + 8'd1;
    assign base_byte = {1'b0, next_idx, 3'b000};

    assign term_pos  = 12'(FRAME_OVERHEAD - 1) + {1'b0, len_q};
    assign last_word = 8'(term_pos >> 3);

    // Classify the eight bytes of the word about to be loaded and gather the
    // FCS-covered ones for the CRC update.
    always_comb begin
        crc_data = '0;
        crc_mask = '0;
        for (int i = 0; i < 8; i++) begin
            lanes[i]            = frame_lane(base_byte + 12'(i), cur_len, cur_seed);
            crc_data[8*i +: 8]  = lanes[i].value;
            crc_mask[i]         = (lanes[i].kind == LANE_CRC);
        end
    end

    crc32_d64 u_crc (
        .crc_in  (crc_base),
        .data    (crc_data),
        .lane_en (crc_mask),
        .crc_out (crc_next)
    );

    // FCS lanes always read the CRC after this word's data lanes. When the FCS
    // spills into the next word, that word has no covered lanes, so crc_next
    // equals the registered CRC there.
    assign fcs = ~crc_next;

    // Assemble the outgoing word and control mask from the lane classes.
    always_comb begin
        word_d = '0;
        ctrl_d = '0;
        for (int i = 0; i < 8; i++) begin
            if (lanes[i].kind == LANE_FCS) begin
                word_d[8*i +: 8] = 8'(fcs >> {lanes[i].fcs_idx, 3'b000});
            end else begin
                word_d[8*i +: 8] = lanes[i].value;
            end
            ctrl_d[i] = (lanes[i].kind == LANE_CTRL);
        end
    end

    // State register.
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and control decisions. Nothing advances in FRAME or IPG
    // unless the downstream accepts the current word.
    always_comb begin
        state_d   = state_q;
        load_word = 1'b0;
        load_idle = 1'b0;
        done_d    = 1'b0;
        len_err_d = 1'b0;
        ipg_d     = ipg_q;
        count_d   = frame_count_q;
        unique case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    if (len_is_legal(i_payload_len)) begin
                        state_d   = ST_FRAME;
                        load_word = 1'b1;
                    end else begin
                        len_err_d = 1'b1;
                    end
                end
            end
            ST_FRAME: begin
                if (i_tx_ready) begin
                    if (word_q == last_word) begin
                        state_d   = (IPG_WORDS == 0) ? ST_IDLE : ST_IPG;
                        load_idle = 1'b1;
                        done_d    = 1'b1;
                        count_d   = frame_count_q + 16'd1;
                        ipg_d     = '0;
                    end else begin
                        load_word = 1'b1;
                    end
                end
            end
            ST_IPG: begin
                if (i_tx_ready) begin
                    if (ipg_q == IPG_LAST) begin
                        state_d = ST_IDLE;
                        ipg_d   = '0;
                    end else begin
                        ipg_d = ipg_q + 8'd1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Datapath registers: output word, word index, running CRC, latched request.
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            tx_data_q     <= IDLE_WORD;
            tx_ctrl_q     <= 8'hFF;
            word_q        <= '0;
            crc_q         <= 32'hFFFFFFFF;
            len_q         <= '0;
            seed_q        <= '0;
            ipg_q         <= '0;
            done_q        <= 1'b0;
            len_err_q     <= 1'b0;
            frame_count_q <= '0;
        end else begin
            if (state_q == ST_IDLE && load_word) begin
                len_q  <= i_payload_len;
                seed_q <= i_seed;
            end
            if (load_word) begin
                tx_data_q <= word_d;
                tx_ctrl_q <= ctrl_d;
                word_q    <= next_idx;
                crc_q     <= crc_next;
            end else if (load_idle) begin
                tx_data_q <= IDLE_WORD;
                tx_ctrl_q <= 8'hFF;
            end
            ipg_q         <= ipg_d;
            done_q        <= done_d;
            len_err_q     <= len_err_d;
            frame_count_q <= count_d;
        end
    end

    assign o_tx_data     = tx_data_q;
    assign o_tx_ctrl     = tx_ctrl_q;
    assign o_busy        = (state_q != ST_IDLE);
    assign o_done        = done_q;
    assign o_len_error   = len_err_q;
    assign o_frame_count = frame_count_q;

endmodule

// File: tb/tb_mac_frame_generator.sv
// tb_mac_frame_generator
// Directed bench for mac_frame_generator: reset state, mid-frame reset,
// back-to-back frame spacing, minimum and maximum length frames, rejected
// lengths and a downstream stall. Frames are compared word by word against a
// byte-stream model built from the frame layout, and the FCS is checked
// through the CRC-32 residue.

module tb_mac_frame_generator;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [10:0] payloadLen;
    logic [7:0]  seed;
    logic        txReady;
    logic [63:0] txData;
    logic [7:0]  txCtrl;
    logic        busy;
    logic        done;
    logic        lenError;
    logic [15:0] frameCount;

    int checks = 0;
    int fails  = 0;

    logic [63:0] capData[$];
    logic [7:0]  capCtrl[$];
    logic [63:0] modelData[$];
    logic [7:0]  modelCtrl[$];

    localparam logic [63:0] IDLE_W  = 64'h0707070707070707;
    localparam logic [63:0] WORD0_W = 64'hD5555555555555FB;

    always #5 clk = ~clk;

    mac_frame_generator #(
        .DATA_WIDTH (64),
        .CTRL_WIDTH (8),
        .IPG_WORDS  (2)
    ) dut (
        .clk           (clk),
        .i_rst         (rst),
        .i_start       (start),
        .i_payload_len (payloadLen),
        .i_seed        (seed),
        .i_tx_ready    (txReady),
        .o_tx_data     (txData),
        .o_tx_ctrl     (txCtrl),
        .o_busy        (busy),
        .o_done        (done),
        .o_len_error   (lenError),
        .o_frame_count (frameCount)
    );

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            fails++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic s, input logic [10:0] l, input logic [7:0] sd, input logic r);
        start      = s;
        payloadLen = l;
        seed       = sd;
        txReady    = r;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] crcByte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        logic        fb;
        r = c;
        for (int k = 0; k < 8; k++) begin
            fb = r[0] ^ d[k];
            r  = r >> 1;
            if (fb) r = r ^ 32'hEDB88320;
        end
        return r;
    endfunction

    function automatic logic [63:0] capWord(input int i);
        if (i >= 0 && i < capData.size()) return capData[i];
        return 64'hx;
    endfunction

    function automatic logic [7:0] capCtrlAt(input int i);
        if (i >= 0 && i < capCtrl.size()) return capCtrl[i];
        return 8'hx;
    endfunction

    // Expected frame as a list of {ctrl, byte}, packed into 8-lane words.
    task automatic buildModel(input int l, input logic [7:0] sd);
        logic [8:0]  mb[$];
        logic [47:0] da;
        logic [47:0] sa;
        logic [31:0] c;
        logic [10:0] l11;
        logic [63:0] w;
        logic [7:0]  wc;
        da  = 48'hFFFFFFFFFFFF;
        sa  = 48'h123456789ABC;
        l11 = 11'(l);
        mb.push_back({1'b1, 8'hFB});
        for (int k = 0; k < 6; k++) mb.push_back({1'b0, 8'h55});
        mb.push_back({1'b0, 8'hD5});
        for (int k = 0; k < 6; k++) mb.push_back({1'b0, da[8*k +: 8]});
        for (int k = 0; k < 6; k++) mb.push_back({1'b0, sa[8*k +: 8]});
        mb.push_back({1'b0, l11[7:0]});
        mb.push_back({1'b0, 5'd0, l11[10:8]});
        for (int k = 0; k < l; k++) mb.push_back({1'b0, 8'(sd + 8'(k))});
        c = 32'hFFFFFFFF;
        for (int k = 8; k < mb.size(); k++) c = crcByte(c, mb[k][7:0]);
        c = ~c;
        for (int k = 0; k < 4; k++) mb.push_back({1'b0, c[8*k +: 8]});
        mb.push_back({1'b1, 8'hFD});
        while (mb.size() % 8 != 0) mb.push_back({1'b1, 8'h07});
        modelData.delete();
        modelCtrl.delete();
        for (int wi = 0; wi < mb.size() / 8; wi++) begin
            for (int k = 0; k < 8; k++) begin
                w[8*k +: 8] = mb[8*wi + k][7:0];
                wc[k]       = mb[8*wi + k][8];
            end
            modelData.push_back(w);
            modelCtrl.push_back(wc);
        end
    endtask

    // Records every accepted word until o_done; optionally drops ready for
    // stallLen cycles when word stallAt is on the output.
    task automatic collectFrame(input int stallAt, input int stallLen, output bit gotDone);
        int stalled;
        stalled = 0;
        gotDone = 1'b0;
        capData.delete();
        capCtrl.delete();
        for (int cyc = 0; cyc < 2000 && !gotDone; cyc++) begin
            if (capData.size() == stallAt && stalled < stallLen) begin
                txReady = 1'b0;
                checkOutput($sformatf("stall hold data c%0d", stalled), txData,
                            (stallAt < modelData.size()) ? modelData[stallAt] : 64'h0);
                checkOutput($sformatf("stall hold ctrl c%0d", stalled), 64'(txCtrl),
                            (stallAt < modelCtrl.size()) ? 64'(modelCtrl[stallAt]) : 64'h0);
                stalled++;
            end else begin
                txReady = 1'b1;
                capData.push_back(txData);
                capCtrl.push_back(txCtrl);
            end
            tick();
            if (done) gotDone = 1'b1;
        end
        txReady = 1'b1;
    endtask

    task automatic compareStream(input string tag);
        int bad;
        int first;
        bad   = 0;
        first = -1;
        checkOutput({tag, " word count"}, 64'(capData.size()), 64'(modelData.size()));
        for (int k = 0; k < modelData.size(); k++) begin
            if (capWord(k) !== modelData[k] || capCtrlAt(k) !== modelCtrl[k]) begin
                bad++;
                if (first < 0) first = k;
            end
        end
        checkOutput($sformatf("%s stream (first bad word %0d)", tag, first), 64'(bad), 64'd0);
    endtask

    task automatic checkResidue(input string tag, input int l);
        logic [31:0] c;
        logic [63:0] w;
        c = 32'hFFFFFFFF;
        for (int b = 8; b <= 25 + l; b++) begin
            w = capWord(b / 8);
            c = crcByte(c, 8'(w >> (8 * (b % 8))));
        end
        checkOutput({tag, " crc residue"}, 64'(c), 64'hDEBB20E3);
    endtask

    initial begin
        bit got;
        int sops[$];

        // Reset state
        applyStimulus(1'b0, 11'd46, 8'd0, 1'b1);
        rst = 1'b1;
        tick();
        tick();
        checkOutput("reset data", txData, IDLE_W);
        checkOutput("reset ctrl", 64'(txCtrl), 64'hFF);
        checkOutput("reset busy", 64'(busy), 64'd0);
        checkOutput("reset done", 64'(done), 64'd0);
        checkOutput("reset len_error", 64'(lenError), 64'd0);
        checkOutput("reset frame_count", 64'(frameCount), 64'd0);
        rst = 1'b0;
        tick();

        // Reset while word 5 of an L=64 frame is on the output
        $display("[TB] mid-frame reset");
        buildModel(64, 8'h80);
        applyStimulus(1'b1, 11'd64, 8'h80, 1'b1);
        tick();
        start = 1'b0;
        repeat (5) tick();
        checkOutput("pre-reset word5", txData, modelData[5]);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("post-reset data", txData, IDLE_W);
        checkOutput("post-reset ctrl", 64'(txCtrl), 64'hFF);
        checkOutput("post-reset busy", 64'(busy), 64'd0);
        checkOutput("post-reset frame_count", 64'(frameCount), 64'd0);

        // Back-to-back frames with start held high
        $display("[TB] back-to-back L=46");
        applyStimulus(1'b1, 11'd46, 8'd0, 1'b1);
        for (int cyc = 0; cyc < 200 && sops.size() < 4; cyc++) begin
            tick();
            if (txCtrl == 8'h01 && txData == WORD0_W) sops.push_back(cyc);
        end
        start = 1'b0;
        checkOutput("b2b frame starts", 64'(sops.size()), 64'd4);
        for (int k = 1; k < sops.size(); k++) begin
            checkOutput($sformatf("b2b period %0d", k), 64'(sops[k] - sops[k-1]), 64'd13);
        end
        for (int cyc = 0; cyc < 60 && busy; cyc++) tick();
        checkOutput("b2b back to idle", 64'(busy), 64'd0);
        checkOutput("b2b frame_count", 64'(frameCount), 64'd4);

        // Minimum length frame, seed 0
        $display("[TB] L=46 seed 0x00");
        buildModel(46, 8'h00);
        applyStimulus(1'b1, 11'd46, 8'h00, 1'b1);
        tick();
        start = 1'b0;
        checkOutput("L46 word0 data", txData, WORD0_W);
        checkOutput("L46 word0 ctrl", 64'(txCtrl), 64'h01);
        checkOutput("L46 busy", 64'(busy), 64'd1);
        collectFrame(-1, 0, got);
        checkOutput("L46 done seen", 64'(got), 64'd1);
        checkOutput("L46 word1", capWord(1), 64'h9ABCFFFFFFFFFFFF);
        checkOutput("L46 word2", capWord(2), 64'h0100002E12345678);
        checkOutput("L46 word8 ctrl", 64'(capCtrlAt(8)), 64'h00);
        checkOutput("L46 word9 data", capWord(9), 64'h07070707070707FD);
        checkOutput("L46 word9 ctrl", 64'(capCtrlAt(9)), 64'hFF);
        compareStream("L46");
        checkResidue("L46", 46);
        checkOutput("L46 frame_count", 64'(frameCount), 64'd5);
        checkOutput("L46 busy in gap", 64'(busy), 64'd1);
        tick();
        checkOutput("L46 done one cycle", 64'(done), 64'd0);
        tick();
        checkOutput("L46 idle after gap", 64'(busy), 64'd0);

        // Maximum length frame, payload wraps past 0xFF
        $display("[TB] L=1500 seed 0xFE");
        buildModel(1500, 8'hFE);
        applyStimulus(1'b1, 11'd1500, 8'hFE, 1'b1);
        tick();
        start = 1'b0;
        collectFrame(-1, 0, got);
        checkOutput("L1500 done seen", 64'(got), 64'd1);
        checkOutput("L1500 word2", capWord(2), 64'hFFFE05DC12345678);
        checkOutput("L1500 word3", capWord(3), 64'h0706050403020100);
        checkOutput("L1500 word190 ctrl", 64'(capCtrlAt(190)), 64'hC0);
        checkOutput("L1500 term lane6", 64'(8'(capWord(190) >> 48)), 64'hFD);
        compareStream("L1500");
        checkResidue("L1500", 1500);
        checkOutput("L1500 frame_count", 64'(frameCount), 64'd6);
        repeat (3) tick();

        // Illegal lengths just below and above the legal range
        $display("[TB] illegal lengths");
        applyStimulus(1'b1, 11'd45, 8'h00, 1'b1);
        tick();
        start = 1'b0;
        checkOutput("L45 len_error", 64'(lenError), 64'd1);
        checkOutput("L45 ctrl", 64'(txCtrl), 64'hFF);
        checkOutput("L45 busy", 64'(busy), 64'd0);
        checkOutput("L45 frame_count", 64'(frameCount), 64'd6);
        tick();
        checkOutput("L45 len_error pulse", 64'(lenError), 64'd0);
        checkOutput("L45 still idle", 64'(busy), 64'd0);
        applyStimulus(1'b1, 11'd1501, 8'h00, 1'b1);
        tick();
        start = 1'b0;
        checkOutput("L1501 len_error", 64'(lenError), 64'd1);
        checkOutput("L1501 ctrl", 64'(txCtrl), 64'hFF);
        checkOutput("L1501 busy", 64'(busy), 64'd0);
        checkOutput("L1501 frame_count", 64'(frameCount), 64'd6);
        tick();
        checkOutput("L1501 len_error pulse", 64'(lenError), 64'd0);

        // Downstream stall of 3 cycles at word 4
        $display("[TB] L=64 stall at word 4");
        buildModel(64, 8'h33);
        applyStimulus(1'b1, 11'd64, 8'h33, 1'b1);
        tick();
        start = 1'b0;
        collectFrame(4, 3, got);
        checkOutput("stall done seen", 64'(got), 64'd1);
        compareStream("stall L64");
        checkResidue("stall L64", 64);
        checkOutput("stall frame_count", 64'(frameCount), 64'd7);
        repeat (3) tick();
        checkOutput("stall idle after gap", 64'(busy), 64'd0);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule

// File: doc/mac_frame_generator.md
# mac_frame_generator

Transmit-side counterpart of the 1.6TMII MAC receive checker. Builds complete Ethernet frames and streams them as 64-bit data words with 8 per-lane control bits, one word per accepted cycle. Each frame carries the start code, preamble, SFD, DA, SA, length/type, an incrementing-pattern payload, CRC-32 FCS and the terminate code, followed by a fixed idle gap. It drives the checker in loopback benches and feeds the TX datapath.

## Interface
- DATA_WIDTH, 64: output data width, 8 byte lanes.
- CTRL_WIDTH, 8: one control bit per lane.
- IPG_WORDS, 2: minimum all-idle words after the terminate word.
- IDLE_CODE 8'h07, START_CODE 8'hFB, TERM_CODE 8'hFD, PREAMBLE_CODE 8'h55, SFD_CODE 8'hD5: line codes.
- DST_ADDR_CODE 48'hFFFFFFFFFFFF, SRC_ADDR_CODE 48'h123456789ABC: header addresses.
- clk  in  1  sole clock; all logic on its rising edge.
- i_rst  in  1  reset, asynchronous, active-high.
- i_start  in  1  frame request, sampled only in IDLE.
- i_payload_len  in  11  payload byte count L; legal range 46..1500.
- i_seed  in  8  first payload byte; payload byte k = (i_seed + k) mod 256.
- i_tx_ready  in  1  downstream accepts the current word; low = hold.
- o_tx_data  out  64  lane i = bits [8i+7:8i]; lane 0 is sent first.
- o_tx_ctrl  out  8  bit i = 1 means lane i carries a control code.
- o_busy  out  1  high in FRAME and IPG.
- o_done  out  1  one-cycle pulse when the terminate word is accepted.
- o_len_error  out  1  one-cycle pulse when a start is rejected.
- o_frame_count  out  16  frames completed, wraps at 65535 -> 0.

## Operation
- Frame byte map, byte index b (total L+27 bytes):
  - b0 START (ctrl); b1..6 PREAMBLE; b7 SFD.
  - b8..13 DA, least significant byte first.
  - b14..19 SA, least significant byte first.
  - b20..21 length/type = L, low byte at b20.
  - b22..21+L payload.
  - b22+L..25+L FCS; b26+L TERM (ctrl); remaining lanes of that word IDLE (ctrl).
- FCS: CRC-32 IEEE 802.3, reflected (poly 0xEDB88320), init 0xFFFFFFFF, final complement. Covers b8..b21+L. FCS[7:0] is sent first.
- States:
  - IDLE: outputs all-idle (data 0x0707070707070707, ctrl 0xFF). If i_start and L is legal: latch L and seed, clear word counter, go to FRAME. If L is illegal: pulse o_len_error and stay in IDLE.
  - FRAME: emit word w = bytes 8w..8w+7. Advance w and CRC only when i_tx_ready = 1. Go to IPG after the word containing TERM is accepted.
  - IPG: emit IPG_WORDS idle words, counting only accepted cycles, then go to IDLE.
- CRC register updates per accepted word over its data lanes only. FCS lanes in the same word as the last payload byte use the combinationally updated CRC. FCS lanes in the following word use the registered CRC.
- i_start outside IDLE is ignored, not queued.

## Timing
- Outputs registered. Start sampled at edge N; word 0 appears after edge N, i.e. 1 cycle latency.
- Word count per frame = ceil((L+27)/8). Back-to-back frames with i_start held high: start-to-start period = ceil((L+27)/8) + IPG_WORDS + 1 cycles (the +1 is the IDLE sample cycle).
- i_tx_ready low: o_tx_data, o_tx_ctrl and all state hold unchanged. o_done fires only on acceptance.
- Reset (asserted at any time, including mid-frame): immediately IDLE; data 0x0707070707070707, ctrl 0xFF, o_busy 0, o_done 0, o_len_error 0, o_frame_count 0. An interrupted frame is not counted.
- o_frame_count increments in the same cycle o_done pulses.

## Structure
- Shared package mac_pkg holds:
  - line-code and address constants;
  - field-size localparams: PREAMBLE 6, SFD 1, DA 6, SA 6, LENGTH 2, FCS 4, MIN/MAX payload 46/1500;
  - the state enum;
  - the byte-lane layout helpers.
- One sub-module, crc32_d64: purely combinational. Inputs are the current CRC, a 64-bit word and an 8-bit lane-enable mask; output is the next CRC. It is shared with the checker's planned hardware FCS path.

## Test plan
- L=46, seed 0, ready=1:
  - 10 words; word 0 = FB 55 55 55 55 55 55 D5 with ctrl 0x01.
  - FCS in word 8 lanes 4-7.
  - Word 9 lane 0 = FD, lanes 1-7 = 07, ctrl 0xFF.
  - o_done with the word-9 acceptance.
- L=1500, seed 0xFE: 191 words; payload wraps FE FF 00 01 ...; TERM at word 190 lane 6. Running CRC over b8..b1525 without final complement yields residue 0xDEBB20E3.
- L=45, and L=1501: o_len_error pulse, ctrl stays 0xFF, o_busy stays 0, o_frame_count unchanged.
- L=64 with i_tx_ready low for 3 cycles at word 4: output word frozen for those 3 cycles; byte stream and FCS identical to the ready=1 run.
- i_rst pulsed during word 5: next cycle outputs idle and o_frame_count unchanged; a new frame then starts cleanly.
- i_start held high, L=46, IPG_WORDS=2: frames start every 13 cycles; the checker loopback reports no errors for 4 frames; o_frame_count = 4.
